// File: rtl/issue_scheduler_if.sv
// Handshake bundle between fetch, the issue queue, the decoder and the backpressure sources.
// master drives the queue inputs; slave is the issue scheduler itself.
interface issue_scheduler_if #(
    parameter int unsigned DEPTH_W = 2
);
    logic               rdy;
    logic               rollback;
    logic               if_valid;
    logic [31:0]        if_inst;
    logic [31:0]        if_pc;
    logic               if_pred_jump;
    logic               if_ready;
    logic               rob_full;
    logic               rs_full;
    logic               lsb_full;
    logic               inst_rdy;
    logic [31:0]        inst;
    logic [31:0]        inst_pc;
    logic               inst_pred_jump;
    logic [DEPTH_W:0]   queue_cnt;

    modport master (
        output rdy, rollback, if_valid, if_inst, if_pc, if_pred_jump,
        output rob_full, rs_full, lsb_full,
        input  if_ready, inst_rdy, inst, inst_pc, inst_pred_jump, queue_cnt
    );

    modport slave (
        input  rdy, rollback, if_valid, if_inst, if_pc, if_pred_jump,
        input  rob_full, rs_full, lsb_full,
        output if_ready, inst_rdy, inst, inst_pc, inst_pred_jump, queue_cnt
    );
endinterface

// File: rtl/issue_scheduler.sv
// In-order instruction queue between fetch and decode; the head issues only when the ROB and
// its target unit (RS or LSB) have room, and the whole queue is flushed on rollback.
module issue_scheduler #(
    parameter int unsigned DEPTH_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    issue_scheduler_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0]   DEPTH_CNT = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_W-1:0] PTR_ONE   = 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_jump;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [DEPTH_W-1:0] head_q, head_d;
    logic [DEPTH_W-1:0] tail_q, tail_d;
    logic [DEPTH_W:0]   cnt_q, cnt_d;

    entry_t head_e;
    logic   not_empty;
    logic   is_lsb;
    logic   can_issue;
    logic   push;
    logic   pop;

    assign head_e    = mem_q[head_q];
    assign not_empty = (cnt_q != '0);
    assign is_lsb    = (head_e.inst[6:0] == 7'b0000011) || (head_e.inst[6:0] == 7'b0100011);
    assign can_issue = not_empty && !bus.rob_full && !(is_lsb ? bus.lsb_full : bus.rs_full);

    // A same-cycle pop never frees a slot for the push; keeps if_ready off the issue path.
    assign bus.if_ready = bus.rdy && !bus.rollback && (cnt_q < DEPTH_CNT);
    assign bus.inst_rdy = bus.rdy && !rst && !bus.rollback && can_issue;

    assign push = bus.if_valid && bus.if_ready;
    assign pop  = bus.inst_rdy;

    assign bus.inst           = not_empty ? head_e.inst : 32'h0;
    assign bus.inst_pc        = not_empty ? head_e.pc : 32'h0;
    assign bus.inst_pred_jump = not_empty ? head_e.pred_jump : 1'b0;
    assign bus.queue_cnt      = cnt_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.rdy) begin
            if (bus.rollback) begin
                head_d = '0;
                tail_d = '0;
                cnt_d  = '0;
            end else begin
                if (push) begin
                    mem_d[tail_q] = '{inst: bus.if_inst, pc: bus.if_pc,
                                      pred_jump: bus.if_pred_jump};
                    tail_d = tail_q + PTR_ONE;
                end
                if (pop) begin
                    head_d = head_q + PTR_ONE;
                end
                unique case ({push, pop})
                    2'b10:   cnt_d = cnt_q + CNT_ONE;
                    2'b01:   cnt_d = cnt_q - CNT_ONE;
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage needs no reset; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_issue_scheduler;
    localparam int unsigned DEPTH_W = 2;
    localparam int unsigned DEPTH   = 1 << DEPTH_W;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    issue_scheduler_if #(.DEPTH_W(DEPTH_W)) bus ();

    issue_scheduler #(.DEPTH_W(DEPTH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pj;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_inst_rdy();
        logic lsb;
        if (q.size() == 0) return 1'b0;
        lsb = (q[0].inst[6:0] == 7'b0000011) || (q[0].inst[6:0] == 7'b0100011);
        return bus.rdy && !rst && !bus.rollback && !bus.rob_full &&
               !(lsb ? bus.lsb_full : bus.rs_full);
    endfunction

    function automatic logic m_if_ready();
        return bus.rdy && !bus.rollback && (q.size() < DEPTH);
    endfunction

    // Reference model: a plain FIFO updated with the architectural rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (bus.rdy) begin
            logic p;
            logic u;
            ent_t e;
            p = m_inst_rdy();
            u = bus.if_valid && m_if_ready();
            if (bus.rollback) begin
                q.delete();
            end else begin
                if (p) void'(q.pop_front());
                if (u) begin
                    e.inst = bus.if_inst;
                    e.pc   = bus.if_pc;
                    e.pj   = bus.if_pred_jump;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_inst_rdy", bus.inst_rdy, m_inst_rdy());
        chk("m_if_ready", bus.if_ready, m_if_ready());
        chk("m_cnt", bus.queue_cnt, q.size());
        chk("m_inst", bus.inst, (q.size() != 0) ? q[0].inst : 32'h0);
        chk("m_pc", bus.inst_pc, (q.size() != 0) ? q[0].pc : 32'h0);
        chk("m_pj", bus.inst_pred_jump, (q.size() != 0) ? q[0].pj : 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bus.if_valid     = v;
        bus.if_inst      = ins;
        bus.if_pc        = pc;
        bus.if_pred_jump = pc[2];
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.rob_full = 1'b0;
        bus.rs_full = 1'b0;
        bus.lsb_full = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_inst_rdy", bus.inst_rdy, 1'b0);
        chk("rst_if_ready", bus.if_ready, 1'b1);
        chk("rst_cnt", bus.queue_cnt, 0);

        // 1: single addi, issues the cycle after the push
        offer(1'b1, 32'h00500093, 32'h0);
        #1;
        chk("t1_no_comb_issue", bus.inst_rdy, 1'b0);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_inst_rdy", bus.inst_rdy, 1'b1);
        chk("t1_inst", bus.inst, 32'h00500093);
        chk("t1_pc", bus.inst_pc, 32'h0);
        chk("t1_cnt1", bus.queue_cnt, 1);
        tick();
        #1;
        chk("t1_cnt0", bus.queue_cnt, 0);

        // 2: fill under rob_full, fifth offer refused
        bus.rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 32'h00000013 | (i << 7), 32'h100 + 4 * i);
            #1;
            chk("t2_if_ready", bus.if_ready, (i < 4));
            tick();
        end
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk("t2_cnt_full", bus.queue_cnt, 4);
        bus.rob_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_issue", bus.inst_rdy, 1'b1);
            chk("t2_pc", bus.inst_pc, 32'h100 + 4 * i);
            tick();
        end
        #1;
        chk("t2_drained", bus.queue_cnt, 0);

        // 3: blocked load head holds back a younger add
        bus.lsb_full = 1'b1;
        offer(1'b1, 32'h0000A103, 32'h200);
        tick();
        offer(1'b1, 32'h002081B3, 32'h204);
        #1;
        chk("t3_blocked_a", bus.inst_rdy, 1'b0);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk("t3_blocked_b", bus.inst_rdy, 1'b0);
        chk("t3_cnt", bus.queue_cnt, 2);
        tick();
        bus.lsb_full = 1'b0;
        #1;
        chk("t3_lw_rdy", bus.inst_rdy, 1'b1);
        chk("t3_lw", bus.inst, 32'h0000A103);
        tick();
        #1;
        chk("t3_add_rdy", bus.inst_rdy, 1'b1);
        chk("t3_add", bus.inst, 32'h002081B3);
        tick();

        // 4: rollback with three queued and a concurrent offer
        bus.rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h00000013, 32'h300 + 4 * i);
            tick();
        end
        bus.rob_full = 1'b0;
        bus.rollback = 1'b1;
        offer(1'b1, 32'h00100093, 32'h3FC);
        #1;
        chk("t4_inst_rdy", bus.inst_rdy, 1'b0);
        chk("t4_if_ready", bus.if_ready, 1'b0);
        tick();
        bus.rollback = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk("t4_cnt", bus.queue_cnt, 0);
        chk("t4_inst", bus.inst, 32'h0);

        // 5: steady-state stream across several pointer wraps
        bus.rob_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 32'h00000013, 32'h500 + 4 * i);
            tick();
        end
        bus.rob_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 32'h00000013, 32'h508 + 4 * i);
            #1;
            chk("t5_issue", bus.inst_rdy, 1'b1);
            chk("t5_pc", bus.inst_pc, 32'h500 + 4 * i);
            chk("t5_cnt", bus.queue_cnt, 2);
            tick();
        end
        offer(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t5_tail_pc", bus.inst_pc, 32'h528 + 4 * i);
            tick();
        end

        // 6: rdy low freezes everything, including rollback; then async reset
        bus.rob_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 32'h00000013, 32'h600 + 4 * i);
            tick();
        end
        bus.rob_full = 1'b0;
        bus.rdy = 1'b0;
        offer(1'b1, 32'h00000013, 32'h6F0);
        for (int i = 0; i < 3; i++) begin
            bus.rollback = (i == 1);
            #1;
            chk("t6_frz_rdy", bus.inst_rdy, 1'b0);
            chk("t6_frz_ifr", bus.if_ready, 1'b0);
            chk("t6_frz_cnt", bus.queue_cnt, 2);
            tick();
        end
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk("t6_resume_rdy", bus.inst_rdy, 1'b1);
        chk("t6_resume_pc", bus.inst_pc, 32'h600);
        chk("t6_resume_cnt", bus.queue_cnt, 2);
        offer(1'b1, 32'h00000013, 32'h6F4);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", bus.queue_cnt, 0);
        chk("t6_rst_rdy", bus.inst_rdy, 1'b0);
        tick();
        rst = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
